seg7_scan_driver: RTL and testbench

//   Consumer end of the BCD digit path: snapshots a 4-digit packed BCD value and

---
 rtl/seg7_scan_driver_pkg.sv | 45 ++++
 rtl/seg7_scan_driver_if.sv | 30 +++
 rtl/seg7_scan_driver_bcd_to_seg7.sv | 31 +++
 rtl/seg7_scan_driver.sv | 104 ++++++++++
 tb/tb_seg7_scan_driver.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-high (bit0=a ... bit6=g); pins invert them.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h67;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [3:0] AN_OFF   = 4'b1111;

    // Index of a display digit; DIG0 is the rightmost digit.
    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_idx_t;

    // Extract the BCD nibble for one digit from the packed value.
    function automatic logic [3:0] digit_nibble(input logic [15:0] v, input digit_idx_t k);
        logic [3:0] n;
        case (k)
            DIG0: n = v[3:0];
            DIG1: n = v[7:4];
            DIG2: n = v[11:8];
            DIG3: n = v[15:12];
        endcase
        return n;
    endfunction

    // Active-low one-hot anode drive for one digit.
    function automatic logic [3:0] anode_for(input digit_idx_t k);
        return ~(4'b0001 << k);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: BCD input side and display pin side of the scan driver.
// master = the block feeding digits and watching the pins; slave = the driver.
interface seg7_scan_driver_if;

    logic [15:0] bcd_in;
    logic        load;
    logic        blank;
    logic [6:0]  seg_cat;
    logic [3:0]  seg_an;
    logic        frame_done;

    modport master (
        output bcd_in,
        output load,
        output blank,
        input  seg_cat,
        input  seg_an,
        input  frame_done
    );

    modport slave (
        input  bcd_in,
        input  load,
        input  blank,
        output seg_cat,
        output seg_an,
        output frame_done
    );

endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// bcd_to_seg7: combinational BCD nibble to active-low cathode pattern.
// Nibbles 10..15 are not valid BCD and are shown as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_cat_o
);

    logic [6:0] seg_on;

    // Look up the lit segments, then invert for the common-anode cathodes.
    always_comb begin
        seg_on = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_on = SEG_0;
            4'd1:    seg_on = SEG_1;
            4'd2:    seg_on = SEG_2;
            4'd3:    seg_on = SEG_3;
            4'd4:    seg_on = SEG_4;
            4'd5:    seg_on = SEG_5;
            4'd6:    seg_on = SEG_6;
            4'd7:    seg_on = SEG_7;
            4'd8:    seg_on = SEG_8;
            4'd9:    seg_on = SEG_9;
            default: seg_on = SEG_DASH;
        endcase
        seg_cat_o = ~seg_on;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: snapshots a packed 4-digit BCD value on a load strobe and
// scans it one-hot across a 4-digit common-anode display, DIGIT_TICKS cycles
// per digit. Pin outputs are registered and change only on slot boundaries.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: darken leading zero digits
// (digit0 always stays lit).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGIT_TICKS = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(DIGIT_TICKS - 1);

    logic [15:0]      snap_q,       snap_d;
    logic [CNT_W-1:0] tick_cnt_q,   tick_cnt_d;
    digit_idx_t       sel_q,        sel_d;
    logic             started_q,    started_d;
    logic [6:0]       seg_cat_q,    seg_cat_d;
    logic [3:0]       seg_an_q,     seg_an_d;
    logic             frame_done_q, frame_done_d;

    logic             tick;
    logic [3:0]       cur_nibble;
    logic [6:0]       dec_cat;
    logic             digit_dark;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Nibble of the digit that the next slot will show.
    always_comb begin
        cur_nibble = digit_nibble(snap_q, sel_q);
    end

    bcd_to_seg7 u_dec (
        .bcd_i     (cur_nibble),
        .seg_cat_o (dec_cat)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are 0.
    always_comb begin
        digit_dark = 1'b0;
        case (sel_q)
            DIG3:    digit_dark = (snap_q[15:12] == 4'd0);
            DIG2:    digit_dark = (snap_q[15:8]  == 8'd0);
            DIG1:    digit_dark = (snap_q[15:4]  == 12'd0);
            default: digit_dark = 1'b0;
        endcase
    end
`else
    assign digit_dark = 1'b0;
`endif

    // Next-state: sel_q names the slot lit on the coming tick; frame_done marks
    // the return to digit0 after digit3, so the first slot after reset (which
    // has no preceding digit3 slot) does not pulse it.
    always_comb begin
        snap_d       = bus.load ? bus.bcd_in : snap_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + CNT_W'(1);
        sel_d        = sel_q;
        started_d    = started_q;
        seg_cat_d    = seg_cat_q;
        seg_an_d     = seg_an_q;
        frame_done_d = 1'b0;
        if (tick) begin
            sel_d        = digit_idx_t'(sel_q + 2'd1);
            started_d    = 1'b1;
            seg_cat_d    = dec_cat;
            seg_an_d     = (bus.blank || digit_dark) ? AN_OFF : anode_for(sel_q);
            frame_done_d = started_q && (sel_q == DIG0);
        end
    end

    // State and output registers; reset darkens the display and restarts the scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_q       <= '0;
            tick_cnt_q   <= '0;
            sel_q        <= DIG0;
            started_q    <= 1'b0;
            seg_cat_q    <= ~SEG_OFF;
            seg_an_q     <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            tick_cnt_q   <= tick_cnt_d;
            sel_q        <= sel_d;
            started_q    <= started_d;
            seg_cat_q    <= seg_cat_d;
            seg_an_q     <= seg_an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.seg_cat    = seg_cat_q;
    assign bus.seg_an     = seg_an_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with DIGIT_TICKS=4.
// Tests push the expected (anode, cathode, frame_done) per slot; a negedge
// monitor pops one entry per tick and checks that outputs hold between ticks.
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .DIGIT_TICKS (4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] cat;
        logic       fd;
    } exp_t;

    localparam exp_t DARK = {4'b1111, 7'b1111111, 1'b0};

    exp_t q[$];
    exp_t last = {4'b1111, 7'b1111111, 1'b0};
    exp_t mon_act;
    exp_t mon_exp;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   e     = 0;
    bit   armed = 1'b0;

    initial begin
        bus.bcd_in = 16'h0000;
        bus.load   = 1'b0;
        bus.blank  = 1'b0;
    end

    function automatic logic [6:0] cat_of(input logic [3:0] n);
        logic [6:0] on;
        case (n)
            4'd0:    on = 7'h3F;
            4'd1:    on = 7'h06;
            4'd2:    on = 7'h5B;
            4'd3:    on = 7'h4F;
            4'd4:    on = 7'h66;
            4'd5:    on = 7'h6D;
            4'd6:    on = 7'h7D;
            4'd7:    on = 7'h07;
            4'd8:    on = 7'h7F;
            4'd9:    on = 7'h67;
            default: on = 7'h40;
        endcase
        return ~on;
    endfunction

    function automatic logic [3:0] an_of(input logic [15:0] v, input int slot, input logic blk);
        logic [3:0] a;
        case (slot)
            0:       a = 4'b1110;
            1:       a = 4'b1101;
            2:       a = 4'b1011;
            default: a = 4'b0111;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if ((slot == 3 && v[15:12] == 4'd0) ||
            (slot == 2 && v[15:8]  == 8'd0) ||
            (slot == 1 && v[15:4]  == 12'd0))
            a = 4'b1111;
`endif
        if (blk) a = 4'b1111;
        return a;
    endfunction

    function automatic exp_t mk(input logic [15:0] v, input int slot, input logic blk, input logic fd);
        logic [3:0] nib;
        nib = v[4*slot +: 4];
        return {an_of(v, slot, blk), cat_of(nib), fd};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic blk, input logic fd0);
        for (int s = 0; s < 4; s++)
            q.push_back(mk(v, s, blk, (s == 0) ? fd0 : 1'b0));
    endtask

    // Edges since reset release; ticks land on multiples of 4.
    always @(posedge clk) begin
        if (rst) e <= 0;
        else     e <= e + 1;
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (armed) begin
            mon_act = {bus.seg_an, bus.seg_cat, bus.frame_done};
            if (e == 0) begin
                mon_exp = DARK;
            end else if (e % 4 == 0) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL scan_unexpected_tick e=%0d: got an=%b cat=%b fd=%b, no expectation queued",
                             e, mon_act.an, mon_act.cat, mon_act.fd);
                    mon_exp = mon_act;
                end else begin
                    mon_exp = q.pop_front();
                end
            end else begin
                mon_exp    = last;
                mon_exp.fd = 1'b0;
            end
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_bad++;
                $display("FAIL scan e=%0d: got an=%b cat=%b fd=%b, expected an=%b cat=%b fd=%b",
                         e, mon_act.an, mon_act.cat, mon_act.fd, mon_exp.an, mon_exp.cat, mon_exp.fd);
            end
            last = mon_exp;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.load = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            step();
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d entries left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        armed = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.seg_an, bus.seg_cat, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state: got an=%b cat=%b fd=%b, expected an=1111 cat=1111111 fd=0",
                     bus.seg_an, bus.seg_cat, bus.frame_done);
        end
        push_frame(16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        wait_drain();
    endtask

    task automatic test_digits();
        logic [15:0] vals [2];
        vals[0] = 16'h1234;
        vals[1] = 16'h9876;
        for (int i = 0; i < 2; i++) begin
            bus.bcd_in = vals[i];
            bus.load   = 1'b1;
            push_frame(vals[i], 1'b0, 1'b1);
            step();
            bus.bcd_in = 16'hFFFF;
            wait_drain();
        end
    endtask

    task automatic test_invalid();
        logic [15:0] vals [2];
        vals[0] = 16'h00A5;
        vals[1] = 16'h0C00;
        for (int i = 0; i < 2; i++) begin
            bus.bcd_in = vals[i];
            bus.load   = 1'b1;
            push_frame(vals[i], 1'b0, 1'b1);
            wait_drain();
        end
    endtask

    task automatic test_leading_zero();
        logic [15:0] vals [2];
        vals[0] = 16'h0000;
        vals[1] = 16'h0105;
        for (int i = 0; i < 2; i++) begin
            bus.bcd_in = vals[i];
            bus.load   = 1'b1;
            push_frame(vals[i], 1'b0, 1'b1);
            wait_drain();
        end
    endtask

    task automatic test_blank();
        bus.blank = 1'b1;
        push_frame(16'h0105, 1'b1, 1'b1);
        wait_drain();
        bus.blank = 1'b0;
        push_frame(16'h0105, 1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_load_on_tick();
        q.push_back(mk(16'h0105, 0, 1'b0, 1'b1));
        for (int s = 1; s < 4; s++)
            q.push_back(mk(16'h4567, s, 1'b0, 1'b0));
        step();
        step();
        bus.bcd_in = 16'h4567;
        bus.load   = 1'b1;
        wait_drain();
        push_frame(16'h4567, 1'b0, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        step();
        rst        = 1'b1;
        bus.bcd_in = 16'h9999;
        bus.load   = 1'b1;
        step();
        n_cmp++;
        if ({bus.seg_an, bus.seg_cat, bus.frame_done} !== {4'b1111, 7'b1111111, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_mid_dark: got an=%b cat=%b fd=%b, expected an=1111 cat=1111111 fd=0",
                     bus.seg_an, bus.seg_cat, bus.frame_done);
        end
        rst = 1'b0;
        push_frame(16'h0000, 1'b0, 1'b0);
        push_frame(16'h0000, 1'b0, 1'b1);
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_digits();
        test_invalid();
        test_leading_zero();
        test_blank();
        test_load_on_tick();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
